// File: rtl/y_enhance_ctrl.sv
// y_enhance_ctrl: per-frame luma-stretch parameter sequencer.
// Divides NUMERATOR by the frame's luma range and commits the result at the next start-of-frame.
module y_enhance_ctrl #(
    parameter logic [15:0] NUMERATOR  = 16'hFF00,
    parameter logic [15:0] UNITY_RATE = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stat_valid,
    output logic        stat_ready,
    input  logic [7:0]  stat_min,
    input  logic [7:0]  stat_max,
    input  logic        frame_sop,
    input  logic        bypass,
    input  logic [7:0]  diff_threshold,
    output logic [15:0] rate,
    output logic [7:0]  min_out,
    output logic        diff2small,
    output logic        params_updated,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, DIV, PEND} state_t;
    state_t state;

    logic [7:0]  diff_c;
    logic        small_c;
    logic        fast_c;
    logic        accept;
    logic [3:0]  iter_cnt;
    logic [8:0]  rem_p0;
    logic [15:0] quo_p0;
    logic [7:0]  divisor_p0;
    logic [7:0]  min_lat;
    logic        small_lat;
    logic [9:0]  step;
    logic [15:0] quo_next;
    logic [15:0] pend_rate;
    logic [7:0]  pend_min;
    logic        pend_small;

    // One restoring-division step: returns {next remainder, quotient bit}.
    function automatic logic [9:0] div_step(input logic [8:0] rem, input logic bit_in,
                                            input logic [7:0] d);
        logic [9:0] trial;
        trial = {rem, bit_in};
        if (trial >= {2'b00, d})
            div_step = {trial[8:0] - {1'b0, d}, 1'b1};
        else
            div_step = {trial[8:0], 1'b0};
    endfunction

    always_comb begin
        diff_c   = (stat_max < stat_min) ? 8'd0 : stat_max - stat_min;
        small_c  = (diff_c <= diff_threshold);
        fast_c   = bypass || (diff_c == 8'd0);
        accept   = stat_valid && stat_ready;
        step     = div_step(rem_p0, quo_p0[15], divisor_p0);
        quo_next = {quo_p0[14:0], step[0]};
    end

    // Divider datapath: quo_p0 shifts the dividend out MSB first and the quotient in at the LSB.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_p0     <= 9'd0;
            quo_p0     <= NUMERATOR;
            divisor_p0 <= diff_c;
            min_lat    <= stat_min;
            small_lat  <= small_c;
        end else if (state == DIV) begin
            rem_p0 <= step[9:1];
            quo_p0 <= quo_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            stat_ready     <= 1'b1;
            busy           <= 1'b0;
            iter_cnt       <= 4'd0;
            rate           <= UNITY_RATE;
            min_out        <= 8'd0;
            diff2small     <= 1'b0;
            params_updated <= 1'b0;
            pend_rate      <= UNITY_RATE;
            pend_min       <= 8'd0;
            pend_small     <= 1'b0;
        end else begin
            params_updated <= 1'b0;
            if (state == PEND && frame_sop) begin
                rate           <= pend_rate;
                min_out        <= pend_min;
                diff2small     <= pend_small;
                params_updated <= 1'b1;
                state          <= IDLE;
            end
            // A new acceptance in the same cycle overrides the commit's return to IDLE.
            case (state)
                IDLE, PEND: begin
                    if (stat_valid) begin
                        iter_cnt <= 4'd0;
                        if (fast_c) begin
                            pend_rate  <= UNITY_RATE;
                            pend_min   <= 8'd0;
                            pend_small <= small_c;
                            state      <= PEND;
                        end else begin
                            state      <= DIV;
                            busy       <= 1'b1;
                            stat_ready <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    iter_cnt <= iter_cnt + 4'd1;
                    if (iter_cnt == 4'd15) begin
                        pend_rate  <= quo_next;
                        pend_min   <= min_lat;
                        pend_small <= small_lat;
                        state      <= PEND;
                        busy       <= 1'b0;
                        stat_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_y_enhance_ctrl.sv
// Scoreboard bench for y_enhance_ctrl: an edge-level reference model queues expected commits,
// a negedge monitor compares committed outputs, busy and stat_ready every cycle.
module tb_y_enhance_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stat_valid = 1'b0;
    logic        frame_sop = 1'b0;
    logic        bypass = 1'b0;
    logic [7:0]  stat_min = 8'd0;
    logic [7:0]  stat_max = 8'd0;
    logic [7:0]  diff_threshold = 8'd0;
    logic        stat_ready;
    logic [15:0] rate;
    logic [7:0]  min_out;
    logic        diff2small;
    logic        params_updated;
    logic        busy;

    y_enhance_ctrl dut (
        .clk(clk), .rst(rst), .stat_valid(stat_valid), .stat_ready(stat_ready),
        .stat_min(stat_min), .stat_max(stat_max), .frame_sop(frame_sop), .bypass(bypass),
        .diff_threshold(diff_threshold), .rate(rate), .min_out(min_out),
        .diff2small(diff2small), .params_updated(params_updated), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] rate;
        logic [7:0]  mn;
        logic        sm;
    } res_t;

    localparam res_t RESET_RES = '{rate: 16'h0100, mn: 8'd0, sm: 1'b0};

    int     checks = 0;
    int     failures = 0;
    res_t   exp_q[$];
    res_t   cur_exp = RESET_RES;

    // Reference model state: a frame's result becomes committable at ready_edge.
    longint edge_n = 0;
    longint ready_edge = 0;
    bit     pend_valid = 1'b0;
    res_t   pend = RESET_RES;
    bit     exp_busy = 1'b0;
    bit     in_div;
    int     d;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            pend_valid = 1'b0;
            exp_q.delete();
            cur_exp  = RESET_RES;
            exp_busy = 1'b0;
        end else begin
            in_div = pend_valid && (edge_n < ready_edge);
            if (!in_div && frame_sop && pend_valid) begin
                exp_q.push_back(pend);
                pend_valid = 1'b0;
            end
            if (!in_div && stat_valid) begin
                d = (stat_max >= stat_min) ? int'(stat_max) - int'(stat_min) : 0;
                pend.sm = (d <= int'(diff_threshold));
                if (bypass || d == 0) begin
                    pend.rate  = 16'h0100;
                    pend.mn    = 8'd0;
                    ready_edge = edge_n + 1;
                end else begin
                    pend.rate  = 16'(65280 / d);
                    pend.mn    = stat_min;
                    ready_edge = edge_n + 17;
                end
                pend_valid = 1'b1;
            end
            exp_busy = pend_valid && (edge_n + 1 < ready_edge);
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (params_updated) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL params_updated: got 1 expected 0 (no commit due) at %0t", $time);
                end else begin
                    cur_exp = exp_q.pop_front();
                end
            end
            chk("rate", rate, cur_exp.rate);
            chk("min_out", {8'd0, min_out}, {8'd0, cur_exp.mn});
            chk("diff2small", {15'd0, diff2small}, {15'd0, cur_exp.sm});
            chk("busy", {15'd0, busy}, {15'd0, exp_busy});
            chk("stat_ready", {15'd0, stat_ready}, {15'd0, !exp_busy});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] thr,
                        input logic byp, input logic with_sop);
        bit rdy;
        int guard;
        guard          = 0;
        stat_min       = mn;
        stat_max       = mx;
        diff_threshold = thr;
        bypass         = byp;
        stat_valid     = 1'b1;
        frame_sop      = with_sop;
        do begin
            rdy = stat_ready;
            tick(1);
            frame_sop = 1'b0;
            guard++;
        end while (!rdy && guard < 200);
        stat_valid = 1'b0;
        checks++;
        if (!rdy) begin
            failures++;
            $display("FAIL accept_timeout: got stat_ready=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic sop();
        frame_sop = 1'b1;
        tick(1);
        frame_sop = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(2);

        // Normal divide, then a late sop.
        send(8'd16, 8'd240, 8'd8, 1'b0, 1'b0);
        tick(20); sop(); tick(3);

        // diff=1 gives the maximum quotient; equal min/max takes the fast path.
        send(8'd100, 8'd101, 8'd0, 1'b0, 1'b0);
        tick(18); sop(); tick(2);
        send(8'd50, 8'd50, 8'd0, 1'b0, 1'b0);
        tick(1); sop(); tick(2);

        // Bypass, then a low-contrast frame.
        send(8'd16, 8'd240, 8'd0, 1'b1, 1'b0);
        tick(2); sop(); tick(2);
        send(8'd20, 8'd30, 8'd10, 1'b0, 1'b0);
        tick(18); sop(); tick(2);

        // Second frame offered mid-division overwrites the first pending result.
        send(8'd10, 8'd200, 8'd0, 1'b0, 1'b0);
        tick(3);
        send(8'd30, 8'd90, 8'd0, 1'b0, 1'b0);
        tick(20); sop(); tick(2);

        // Coincident sop and new stats in PEND.
        send(8'd5, 8'd105, 8'd0, 1'b0, 1'b0);
        tick(18);
        send(8'd40, 8'd140, 8'd0, 1'b0, 1'b1);
        tick(20); sop(); tick(2);

        // Reset in the middle of a division: nothing may commit afterwards.
        send(8'd16, 8'd240, 8'd0, 1'b0, 1'b0);
        tick(7); pulse_reset();
        tick(20); sop(); tick(3);

        // min > max clamps diff to zero.
        send(8'd200, 8'd100, 8'd3, 1'b0, 1'b0);
        tick(2); sop(); tick(2);

        for (int i = 0; i < 150; i++) begin
            logic [7:0] mn;
            logic [7:0] mx;
            mn = 8'($urandom_range(0, 255));
            mx = ($urandom_range(0, 3) == 0) ? 8'(int'(mn) + $urandom_range(0, 3))
                                            : 8'($urandom_range(0, 255));
            send(mn, mx, 8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0));
            tick($urandom_range(0, 22));
            if ($urandom_range(0, 2) != 0) sop();
            tick($urandom_range(0, 3));
        end

        tick(20); sop(); tick(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL commit_queue: got %0d uncommitted results expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
